fetch_unit: RTL and testbench

//  Instruction-fetch stage for the MIPS core. Holds the PC and fetches one 32-bit word per instruction

---
 rtl/fetch_unit_pkg.sv | 17 +
 rtl/fetch_unit_if.sv | 15 +
 rtl/next_pc_sel.sv | 29 ++
 rtl/fetch_unit.sv | 89 ++++++++
 tb/tb_fetch_unit.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_unit_pkg : shared FSM encoding and reset PC for fetch_unit   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package fetch_unit_pkg;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_EXEC  = 2'd2
   } state_t;

endpackage : fetch_unit_pkg
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_unit_if : instruction-memory req/rvalid bus                  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface fetch_unit_if;
   logic        req;
   logic [31:0] addr;
   logic        rvalid;
   logic [31:0] rdata;

   modport master (output req, output addr, input  rvalid, input  rdata);
   modport slave  (input  req, input  addr, output rvalid, output rdata);
endinterface : fetch_unit_if
`default_nettype wire

// File: rtl/next_pc_sel.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | next_pc_sel : jump / branch / sequential next-PC selection         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module next_pc_sel (
   input  logic [31:0] pc_plus4,
   input  logic [25:0] instr_idx,
   input  logic        pcsrc,
   input  logic        jump,
   output logic [31:0] next_pc
);

   logic [31:0] br_off;

   assign br_off = {{14{instr_idx[15]}}, instr_idx[15:0], 2'b00};

   // jump outranks a taken branch
   always_comb begin
      next_pc = pc_plus4;
      if (jump) begin
         next_pc = {pc_plus4[31:28], instr_idx, 2'b00};
      end else if (pcsrc) begin
         next_pc = pc_plus4 + br_off;
      end
   end

endmodule : next_pc_sel
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_unit : PC, instruction register and fetch/exec sequencing    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic         clk,
   input  logic         rst_n,
   fetch_unit_if.master imem,
   input  logic         stall,
   input  logic         pcsrc,
   input  logic         jump,
   output logic [31:0]  instr,
   output logic [5:0]   op,
   output logic [5:0]   funct,
   output logic         instr_valid,
   output logic [31:0]  pc,
   output logic [31:0]  pc_plus4
);

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] next_pc;

   assign pc        = pc_q;
   assign pc_plus4  = pc_q + 32'd4;
   assign instr     = instr_q;
   assign op        = instr_q[31:26];
   assign funct     = instr_q[5:0];
   assign imem.addr = pc_q;

   next_pc_sel u_next_pc_sel (
      .pc_plus4  (pc_plus4),
      .instr_idx (instr_q[25:0]),
      .pcsrc     (pcsrc),
      .jump      (jump),
      .next_pc   (next_pc)
   );

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      instr_d     = instr_q;
      imem.req    = 1'b0;
      instr_valid = 1'b0;
      case (state_q)
         S_IDLE: begin
            state_d = S_FETCH;
         end
         S_FETCH: begin
            imem.req = 1'b1;
            if (imem.rvalid) begin
               instr_d = imem.rdata;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            instr_valid = 1'b1;
            if (!stall) begin
               pc_d    = next_pc;
               state_d = S_FETCH;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // low address bits are forced clear so a misaligned RESET_PC cannot leak out
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         pc_q    <= {RESET_PC[31:2], 2'b00};
         instr_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
      end
   end

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fetch_unit : randomized scoreboard bench for fetch_unit         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   typedef struct {
      logic [31:0] addr;
      int          cycles;
   } fetch_exp_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      int          cycles;
   } exec_exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0;
   logic        pcsrc = 1'b0;
   logic        jump = 1'b0;
   logic [31:0] instr;
   logic [5:0]  op;
   logic [5:0]  funct;
   logic        instr_valid;
   logic [31:0] pc;
   logic [31:0] pc_plus4;

   fetch_unit_if bus ();

   fetch_unit #(.RESET_PC(RST_PC)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem        (bus),
      .stall       (stall),
      .pcsrc       (pcsrc),
      .jump        (jump),
      .instr       (instr),
      .op          (op),
      .funct       (funct),
      .instr_valid (instr_valid),
      .pc          (pc),
      .pc_plus4    (pc_plus4)
   );

   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;

   fetch_exp_t  addr_q[$];
   exec_exp_t   exec_q[$];
   logic [31:0] model_pc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] ins,
                                              input bit br, input bit jp);
      logic [31:0] seq;
      int          off;
      seq = cur + 32'd4;
      if (jp) return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
      if (br) begin
         off = int'($signed(ins[15:0])) * 4;
         return seq + 32'(off);
      end
      return seq;
   endfunction

   // Monitor: pops expectations when the DUT starts a fetch or presents an instruction
   fetch_exp_t cur_f;
   exec_exp_t  cur_e;
   bit         in_req = 0, in_ex = 0;
   int         req_cnt = 0, ex_cnt = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         in_req = 0;
         in_ex  = 0;
      end else begin
         if (bus.req === 1'b1 && instr_valid === 1'b1) chk("req_and_valid_overlap", 32'd1, 32'd0);
         if (bus.req === 1'b1) begin
            if (!in_req) begin
               if (addr_q.size() == 0) begin
                  chk("unexpected_fetch", bus.addr, 32'hDEAD_BEEF);
                  cur_f = '{bus.addr, 0};
               end else begin
                  cur_f = addr_q.pop_front();
               end
               in_req  = 1;
               req_cnt = 1;
            end else begin
               req_cnt++;
            end
            chk("fetch_addr", bus.addr, cur_f.addr);
         end else if (in_req) begin
            chk("req_hold_cycles", 32'(req_cnt), 32'(cur_f.cycles));
            in_req = 0;
         end
         if (instr_valid === 1'b1) begin
            if (!in_ex) begin
               if (exec_q.size() == 0) begin
                  chk("unexpected_exec", instr, 32'hDEAD_BEEF);
                  cur_e = '{pc, instr, 0};
               end else begin
                  cur_e = exec_q.pop_front();
               end
               in_ex  = 1;
               ex_cnt = 1;
               chk("op", 32'(op), 32'(cur_e.instr >> 26));
               chk("funct", 32'(funct), 32'(cur_e.instr & 32'h3F));
               chk("pc_plus4", pc_plus4, cur_e.pc + 32'd4);
            end else begin
               ex_cnt++;
            end
            chk("exec_instr", instr, cur_e.instr);
            chk("exec_pc", pc, cur_e.pc);
         end else if (in_ex) begin
            chk("valid_cycles", 32'(ex_cnt), 32'(cur_e.cycles));
            in_ex = 0;
         end
      end
   end

   task automatic wait_req();
      int n = 0;
      while (bus.req !== 1'b1 && n < 8) begin
         @(posedge clk); #1;
         n++;
      end
      if (bus.req !== 1'b1) chk("req_timeout", 32'(bus.req), 32'd1);
   endtask

   task automatic do_instr(input logic [31:0] data, input int lat, input int stl,
                           input bit br, input bit jp);
      addr_q.push_back('{model_pc, lat + 1});
      wait_req();
      stall = 1'b0;
      for (int i = 0; i < lat; i++) begin
         bus.rvalid = 1'b0;
         bus.rdata  = $urandom;
         pcsrc      = 1'($urandom);
         jump       = 1'($urandom);
         @(posedge clk); #1;
      end
      bus.rvalid = 1'b1;
      bus.rdata  = data;
      exec_q.push_back('{model_pc, data, stl + 1});
      @(posedge clk); #1;
      for (int i = 0; i < stl; i++) begin
         stall      = 1'b1;
         pcsrc      = 1'($urandom);
         jump       = 1'($urandom);
         bus.rvalid = 1'($urandom);
         bus.rdata  = $urandom;
         @(posedge clk); #1;
      end
      stall      = 1'b0;
      pcsrc      = br;
      jump       = jp;
      bus.rvalid = 1'($urandom);
      bus.rdata  = $urandom;
      @(posedge clk); #1;
      model_pc   = model_next(model_pc, data, br, jp);
      bus.rvalid = 1'b0;
      pcsrc      = 1'b0;
      jump       = 1'b0;
   endtask

   task automatic chk_reset_outputs();
      chk("rst_pc", pc, RST_PC);
      chk("rst_req", 32'(bus.req), 32'd0);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_instr", instr, 32'd0);
      chk("rst_op", 32'(op), 32'd0);
      chk("rst_funct", 32'(funct), 32'd0);
   endtask

   initial begin
      bus.rvalid = 1'b0;
      bus.rdata  = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_outputs();
      rst_n    = 1'b1;
      model_pc = RST_PC;

      do_instr(32'h2010_0005, 0, 0, 1'b0, 1'b0);  // addi: op 0x08, next 0x4
      do_instr(32'h0000_0020, 3, 0, 1'b0, 1'b0);  // three wait states
      do_instr(32'h0000_0000, 1, 0, 1'b0, 1'b0);
      do_instr(32'h0000_0000, 0, 0, 1'b0, 1'b0);  // pc now 0x10
      do_instr(32'h1000_FFFE, 0, 0, 1'b1, 1'b0);  // taken -> 0x0C
      do_instr(32'h0000_0000, 0, 0, 1'b0, 1'b0);  // -> 0x10
      do_instr(32'h1000_FFFE, 2, 0, 1'b0, 1'b0);  // not taken -> 0x14
      do_instr(32'h1000_FFF9, 0, 0, 1'b1, 1'b0);  // 0x18 - 0x1C -> 0xFFFF_FFFC
      do_instr(32'h0000_0000, 0, 3, 1'b0, 1'b0);  // stall 3, wraps to 0
      do_instr(32'h0800_0010, 0, 0, 1'b1, 1'b1);  // jump beats branch -> 0x40
      do_instr(32'h1000_8000, 0, 0, 1'b1, 1'b0);  // -> 0xFFFE_0044
      do_instr(32'h0800_0010, 1, 1, 1'b1, 1'b1);  // -> 0xF000_0040
      chk("model_pc_after_jump", model_pc, 32'hF000_0040);

      for (int k = 0; k < 200; k++) begin
         do_instr($urandom, int'($urandom_range(0, 3)),
                  ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3)),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0));
      end

      // reset in the middle of a fetch, with a response arriving during reset
      addr_q.push_back('{model_pc, 99});
      wait_req();
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n      = 1'b0;
      bus.rvalid = 1'b1;
      bus.rdata  = $urandom;
      @(posedge clk); #1;
      chk_reset_outputs();
      @(posedge clk); #1;
      chk_reset_outputs();
      addr_q.delete();
      exec_q.delete();
      rst_n      = 1'b1;
      bus.rvalid = 1'b0;
      model_pc   = RST_PC;
      @(posedge clk); #1;
      chk("bubble_then_req", 32'(bus.req), 32'd1);
      chk("bubble_then_addr", bus.addr, RST_PC);

      for (int k = 0; k < 30; k++) begin
         do_instr($urandom, int'($urandom_range(0, 2)), int'($urandom_range(0, 1)),
                  1'($urandom), ($urandom_range(0, 3) == 0));
      end

      addr_q.push_back('{model_pc, 0});
      repeat (3) @(posedge clk);
      #1;
      chk("exec_queue_drained", 32'(exec_q.size()), 32'd0);
      chk("addr_queue_drained", 32'(addr_q.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule : tb_fetch_unit
`default_nettype wire
